usb_token_rx: RTL and testbench

USB_TOKEN_RX -- requirements
Module: usb_token_rx

---
 rtl/usb_token_rx.sv | 179 +++++++++++++++++
 tb/tb_usb_token_rx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_token_rx.sv
// usb_token_rx -- USB token/handshake packet parser with CRC5 check and error reporting.
// Rev 1.0
`default_nettype none

module usb_token_rx #(
  parameter int ENDP_NUM       = 16,
  parameter int ADDR_FILTER_EN = 1,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       self_addr,
  input  logic             rx_handshake_on,
  input  logic             cnt_clr,
  input  logic             rx_lp_sop,
  input  logic             rx_lp_eop,
  input  logic             rx_lp_valid,
  input  logic [7:0]       rx_lp_data,
  output logic             rx_lp_ready,
  output logic             rx_pid_en,
  output logic [3:0]       rx_pid,
  output logic [6:0]       rx_addr,
  output logic [3:0]       rx_endp,
  output logic             rx_sof_en,
  output logic [10:0]      rx_frame,
  output logic             crc5_err,
  output logic             pid_err,
  output logic             len_err,
  output logic             endp_err,
  output logic [CNT_W-1:0] crc5_err_cnt
);

  typedef enum logic [1:0] {IDLE, TOK1, TOK2, DROP} state_t;

  localparam logic [4:0] ENDP_LIM    = 5'(ENDP_NUM);
  localparam logic [4:0] CRC_RESIDUE = 5'b01100;
  localparam logic [3:0] PID_SOF     = 4'h5;

  state_t     state;
  logic [3:0] tok_pid;
  logic [7:0] byte1;

  logic       pid_ok;
  logic       is_tok;
  logic       is_hs;
  logic       crc_ok;
  logic       crc_hit;
  logic [6:0] tok_addr;
  logic [3:0] tok_endp;
  logic       addr_miss;
  logic       endp_bad;

  // Residue check over the full 16-bit token body (payload plus transmitted CRC).
  function automatic logic [4:0] crc5_residue(input logic [15:0] bits);
    logic [4:0] c;
    logic       fb;
    c = 5'b11111;
    for (int i = 0; i < 16; i++) begin
      fb = c[4] ^ bits[i];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    return c;
  endfunction

  assign rx_lp_ready = 1'b1;
  assign pid_ok      = (rx_lp_data[3:0] == ~rx_lp_data[7:4]);
  assign crc_ok      = (crc5_residue({rx_lp_data, byte1}) == CRC_RESIDUE);
  assign tok_addr    = byte1[6:0];
  assign tok_endp    = {rx_lp_data[2:0], byte1[7]};
  assign addr_miss   = (ADDR_FILTER_EN != 0) && (tok_addr != self_addr);
  assign endp_bad    = ({1'b0, tok_endp} >= ENDP_LIM);
  assign crc_hit     = rx_lp_valid && !rx_lp_sop && (state == TOK2) && rx_lp_eop && !crc_ok;

  always_comb begin
    is_tok = 1'b0;
    is_hs  = 1'b0;
    case (rx_lp_data[3:0])
      4'h1, 4'h9, 4'hD, 4'h4, 4'h5: is_tok = 1'b1;
      4'h2, 4'hA, 4'hE, 4'h6:       is_hs  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tok_pid      <= 4'h0;
      byte1        <= 8'h00;
      rx_pid_en    <= 1'b0;
      rx_pid       <= 4'h0;
      rx_addr      <= 7'h00;
      rx_endp      <= 4'h0;
      rx_sof_en    <= 1'b0;
      rx_frame     <= 11'h000;
      crc5_err     <= 1'b0;
      pid_err      <= 1'b0;
      len_err      <= 1'b0;
      endp_err     <= 1'b0;
      crc5_err_cnt <= '0;
    end else begin
      rx_pid_en <= 1'b0;
      rx_sof_en <= 1'b0;
      crc5_err  <= 1'b0;
      pid_err   <= 1'b0;
      len_err   <= 1'b0;
      endp_err  <= 1'b0;

      if (rx_lp_valid) begin
        if (rx_lp_sop) begin
          // A new sop always restarts parsing; any partial packet is silently lost.
          if (!pid_ok) begin
            pid_err <= 1'b1;
            state   <= rx_lp_eop ? IDLE : DROP;
          end else if (is_tok && !rx_lp_eop && !rx_handshake_on) begin
            tok_pid <= rx_lp_data[3:0];
            state   <= TOK1;
          end else if (is_hs && !rx_lp_eop) begin
            len_err <= 1'b1;
            state   <= DROP;
          end else if (is_hs && rx_handshake_on) begin
            rx_pid_en <= 1'b1;
            rx_pid    <= rx_lp_data[3:0];
            state     <= IDLE;
          end else begin
            state <= rx_lp_eop ? IDLE : DROP;
          end
        end else begin
          case (state)
            IDLE: ;
            TOK1: begin
              byte1 <= rx_lp_data;
              if (rx_lp_eop) begin
                len_err <= 1'b1;
                state   <= IDLE;
              end else begin
                state <= TOK2;
              end
            end
            TOK2: begin
              if (rx_lp_eop) begin
                state <= IDLE;
                if (!crc_ok) begin
                  crc5_err <= 1'b1;
                end else if (tok_pid == PID_SOF) begin
                  rx_sof_en <= 1'b1;
                  rx_pid    <= tok_pid;
                  rx_frame  <= {rx_lp_data[2:0], byte1};
                end else if (addr_miss) begin
                  // Token for another device: dropped without any indication.
                end else if (endp_bad) begin
                  endp_err <= 1'b1;
                end else begin
                  rx_pid_en <= 1'b1;
                  rx_pid    <= tok_pid;
                  rx_addr   <= tok_addr;
                  rx_endp   <= tok_endp;
                end
              end else begin
                len_err <= 1'b1;
                state   <= DROP;
              end
            end
            DROP: if (rx_lp_eop) state <= IDLE;
            default: state <= IDLE;
          endcase
        end
      end

      if (cnt_clr) begin
        crc5_err_cnt <= '0;
      end else if (crc_hit && (crc5_err_cnt != '1)) begin
        crc5_err_cnt <= crc5_err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_usb_token_rx.sv
// tb_usb_token_rx -- scoreboard bench for usb_token_rx (ENDP_NUM=4, CNT_W=2).
// Rev 1.0
`default_nettype none

module tb_usb_token_rx;

  localparam logic [5:0] K_PID  = 6'b100000;
  localparam logic [5:0] K_SOF  = 6'b010000;
  localparam logic [5:0] K_CRC  = 6'b001000;
  localparam logic [5:0] K_PIDE = 6'b000100;
  localparam logic [5:0] K_LEN  = 6'b000010;
  localparam logic [5:0] K_ENDP = 6'b000001;

  typedef struct {
    logic [5:0]  kind;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [10:0] frame;
    logic [1:0]  cnt;
    logic        cmp_pid;
    logic        cmp_ae;
    logic        cmp_frame;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  self_addr = 7'h00;
  logic        rx_handshake_on = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        rx_lp_sop = 1'b0;
  logic        rx_lp_eop = 1'b0;
  logic        rx_lp_valid = 1'b0;
  logic [7:0]  rx_lp_data = 8'h00;
  logic        rx_lp_ready;
  logic        rx_pid_en;
  logic [3:0]  rx_pid;
  logic [6:0]  rx_addr;
  logic [3:0]  rx_endp;
  logic        rx_sof_en;
  logic [10:0] rx_frame;
  logic        crc5_err;
  logic        pid_err;
  logic        len_err;
  logic        endp_err;
  logic [1:0]  crc5_err_cnt;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  logic [1:0] exp_cnt = 2'd0;

  usb_token_rx #(.ENDP_NUM(4), .ADDR_FILTER_EN(1), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .self_addr(self_addr),
    .rx_handshake_on(rx_handshake_on), .cnt_clr(cnt_clr),
    .rx_lp_sop(rx_lp_sop), .rx_lp_eop(rx_lp_eop), .rx_lp_valid(rx_lp_valid),
    .rx_lp_data(rx_lp_data), .rx_lp_ready(rx_lp_ready),
    .rx_pid_en(rx_pid_en), .rx_pid(rx_pid), .rx_addr(rx_addr), .rx_endp(rx_endp),
    .rx_sof_en(rx_sof_en), .rx_frame(rx_frame),
    .crc5_err(crc5_err), .pid_err(pid_err), .len_err(len_err), .endp_err(endp_err),
    .crc5_err_cnt(crc5_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Transmitter-side CRC5 generator: returns {byte2, byte1} for an 11-bit token field.
  function automatic logic [15:0] tok_bytes(input logic [6:0] a, input logic [3:0] ep);
    logic [10:0] v;
    logic [4:0]  c;
    logic [4:0]  r;
    logic        fb;
    v = {ep, a};
    c = 5'b11111;
    for (int i = 0; i < 11; i++) begin
      fb = c[4] ^ v[i];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    for (int k = 0; k < 5; k++) r[k] = ~c[4-k];
    return {r, ep[3:1], ep[0], a};
  endfunction

  task automatic send(input logic [7:0] d, input logic s, input logic e);
    rx_lp_data  = d;
    rx_lp_sop   = s;
    rx_lp_eop   = e;
    rx_lp_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_lp_valid = 1'b0;
    rx_lp_sop   = 1'b0;
    rx_lp_eop   = 1'b0;
  endtask

  task automatic bubble(input logic [7:0] d, input logic s, input logic e);
    rx_lp_data  = d;
    rx_lp_sop   = s;
    rx_lp_eop   = e;
    rx_lp_valid = 1'b0;
    @(posedge clk);
    #1;
    rx_lp_sop = 1'b0;
    rx_lp_eop = 1'b0;
  endtask

  task automatic send_tok(input logic [3:0] pid, input logic [15:0] b);
    send({~pid, pid}, 1'b1, 1'b0);
    send(b[7:0], 1'b0, 1'b0);
    send(b[15:8], 1'b0, 1'b1);
  endtask

  task automatic push(input logic [5:0] k, input logic [3:0] p, input logic [6:0] a,
                      input logic [3:0] ep, input logic [10:0] f,
                      input logic cp, input logic cae, input logic cf);
    exp_t e;
    if (k == K_CRC) exp_cnt = (exp_cnt == 2'd3) ? 2'd3 : exp_cnt + 2'd1;
    e.kind = k; e.pid = p; e.addr = a; e.endp = ep; e.frame = f; e.cnt = exp_cnt;
    e.cmp_pid = cp; e.cmp_ae = cae; e.cmp_frame = cf;
    q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    logic [5:0] k;
    exp_t       e;
    if (rst_n) begin
      k = {rx_pid_en, rx_sof_en, crc5_err, pid_err, len_err, endp_err};
      if (q.size() == 0) begin
        if (k != 6'b0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got kind %b required none", k);
        end
      end else begin
        e = q.pop_front();
        chk("event_kind", 32'(k), 32'(e.kind));
        chk("err_cnt", 32'(crc5_err_cnt), 32'(e.cnt));
        if (e.cmp_pid) chk("rx_pid", 32'(rx_pid), 32'(e.pid));
        if (e.cmp_ae) begin
          chk("rx_addr", 32'(rx_addr), 32'(e.addr));
          chk("rx_endp", 32'(rx_endp), 32'(e.endp));
        end
        if (e.cmp_frame) chk("rx_frame", 32'(rx_frame), 32'(e.frame));
      end
    end
  end

  initial begin
    logic [15:0] b;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(rx_lp_ready), 32'd1);
    chk("rst_pulses", 32'({rx_pid_en, rx_sof_en, crc5_err, pid_err, len_err, endp_err}), 32'd0);
    chk("rst_pid", 32'(rx_pid), 32'd0);
    chk("rst_addr_endp", 32'({rx_addr, rx_endp}), 32'd0);
    chk("rst_frame", 32'(rx_frame), 32'd0);
    chk("rst_cnt", 32'(crc5_err_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SETUP addr 0 endp 0, known-good bytes
    send(8'h2D, 1'b1, 1'b0); send(8'h00, 1'b0, 1'b0); send(8'h10, 1'b0, 1'b1);
    push(K_PID, 4'hD, 7'h00, 4'h0, 11'h0, 1'b1, 1'b1, 1'b0);
    // Same packet, corrupted CRC
    send(8'h2D, 1'b1, 1'b0); send(8'h00, 1'b0, 1'b0); send(8'h18, 1'b0, 1'b1);
    push(K_CRC, 4'h0, 7'h00, 4'h0, 11'h0, 1'b0, 1'b0, 1'b0);

    // ACK with and without handshake expectation
    rx_handshake_on = 1'b1;
    send(8'hD2, 1'b1, 1'b1);
    push(K_PID, 4'h2, 7'h00, 4'h0, 11'h0, 1'b1, 1'b0, 1'b0);
    rx_handshake_on = 1'b0;
    send(8'hD2, 1'b1, 1'b1);
    repeat (2) bubble(8'h00, 1'b0, 1'b0);

    // Endpoint 5 beyond ENDP_NUM=4, then endpoint 3 accepted
    self_addr = 7'h15;
    send_tok(4'h1, tok_bytes(7'h15, 4'd5));
    push(K_ENDP, 4'h0, 7'h00, 4'h0, 11'h0, 1'b0, 1'b0, 1'b0);
    send_tok(4'h9, tok_bytes(7'h15, 4'd3));
    push(K_PID, 4'h9, 7'h15, 4'h3, 11'h0, 1'b1, 1'b1, 1'b0);
    // Address mismatch: silent
    send_tok(4'h1, tok_bytes(7'h16, 4'd0));
    bubble(8'h00, 1'b0, 1'b0);
    // SOF ignores address filter
    b = tok_bytes(7'h23, 4'hB);
    send_tok(4'h5, b);
    push(K_SOF, 4'h5, 7'h00, 4'h0, 11'h5A3, 1'b0, 1'b0, 1'b1);
    send_tok(4'h5, tok_bytes(7'h7F, 4'hF));
    push(K_SOF, 4'h5, 7'h00, 4'h0, 11'h7FF, 1'b0, 1'b0, 1'b1);

    // Token aborted after byte1 by ACK
    self_addr = 7'h00;
    send(8'h2D, 1'b1, 1'b0); send(8'h00, 1'b0, 1'b0);
    rx_handshake_on = 1'b1;
    send(8'hD2, 1'b1, 1'b1);
    push(K_PID, 4'h2, 7'h00, 4'h0, 11'h0, 1'b1, 1'b0, 1'b0);
    // Handshake PID without eop
    send(8'hD2, 1'b1, 1'b0);
    push(K_LEN, 4'h0, 7'h00, 4'h0, 11'h0, 1'b0, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b1);
    rx_handshake_on = 1'b0;

    // PID check failure, rest of packet dropped
    send(8'h2C, 1'b1, 1'b0);
    push(K_PIDE, 4'h0, 7'h00, 4'h0, 11'h0, 1'b0, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0); send(8'h10, 1'b0, 1'b1);
    // DATA0 PID dropped
    send(8'hC3, 1'b1, 1'b0); send(8'h00, 1'b0, 1'b0); send(8'h10, 1'b0, 1'b1);
    // Short token and overlong token
    send(8'h2D, 1'b1, 1'b0); send(8'h00, 1'b0, 1'b1);
    push(K_LEN, 4'h0, 7'h00, 4'h0, 11'h0, 1'b0, 1'b0, 1'b0);
    send(8'h2D, 1'b1, 1'b0); send(8'h00, 1'b0, 1'b0); send(8'h10, 1'b0, 1'b0);
    push(K_LEN, 4'h0, 7'h00, 4'h0, 11'h0, 1'b0, 1'b0, 1'b0);
    send(8'h55, 1'b0, 1'b1);

    // Invalid cycles with junk framing must be ignored
    send(8'hE1, 1'b1, 1'b0);
    bubble(8'hD2, 1'b1, 1'b1);
    send(8'h00, 1'b0, 1'b0);
    bubble(8'hFF, 1'b0, 1'b1);
    send(8'h10, 1'b0, 1'b1);
    push(K_PID, 4'h1, 7'h00, 4'h0, 11'h0, 1'b1, 1'b1, 1'b0);

    // Counter clear, saturation and clear-beats-increment
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    exp_cnt = 2'd0;
    chk("cnt_after_clr", 32'(crc5_err_cnt), 32'd0);
    b = tok_bytes(7'h00, 4'd1) ^ 16'h0800;
    for (int i = 0; i < 4; i++) begin
      send_tok(4'hD, b);
      push(K_CRC, 4'h0, 7'h00, 4'h0, 11'h0, 1'b0, 1'b0, 1'b0);
    end
    send(8'h2D, 1'b1, 1'b0); send(b[7:0], 1'b0, 1'b0);
    cnt_clr = 1'b1;
    send(b[15:8], 1'b0, 1'b1);
    cnt_clr = 1'b0;
    exp_cnt = 2'd3;
    push(K_CRC, 4'h0, 7'h00, 4'h0, 11'h0, 1'b0, 1'b0, 1'b0);
    q[q.size()-1].cnt = 2'd0;
    exp_cnt = 2'd0;

    // Reset mid-packet: outputs cleared, tail byte without sop ignored
    send(8'h2D, 1'b1, 1'b0); send(8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_pid", 32'(rx_pid), 32'd0);
    chk("midrst_cnt", 32'(crc5_err_cnt), 32'd0);
    rst_n = 1'b1;
    send(8'h10, 1'b0, 1'b1);
    send(8'h2D, 1'b1, 1'b0); send(8'h00, 1'b0, 1'b0); send(8'h10, 1'b0, 1'b1);
    push(K_PID, 4'hD, 7'h00, 4'h0, 11'h0, 1'b1, 1'b1, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
